// File: rtl/krnl_vadd_pkg.sv
// Shared types and defaults for the vadd kernel read-side plumbing.
package krnl_vadd_pkg;

    localparam int unsigned C_NUM_REQ_DFLT         = 4;
    localparam int unsigned C_MAX_OUTSTANDING_DFLT = 8;

    typedef logic [7:0]                          axi_len_t;
    typedef logic [$clog2(C_NUM_REQ_DFLT)-1:0]   req_idx_t;

endpackage

// File: rtl/krnl_vadd_rd_arbiter_if.sv
// AR/R bundle between the per-input read engines, the arbiter and m00_axi.
interface krnl_vadd_rd_arbiter_if
    import krnl_vadd_pkg::*;
#(
    parameter int unsigned C_NUM_REQ         = C_NUM_REQ_DFLT,
    parameter int unsigned C_ADDR_WIDTH      = 64,
    parameter int unsigned C_DATA_WIDTH      = 128,
    parameter int unsigned C_MAX_OUTSTANDING = C_MAX_OUTSTANDING_DFLT
);

    logic [C_NUM_REQ-1:0]              req_arvalid;
    logic [C_NUM_REQ-1:0]              req_arready;
    logic [C_NUM_REQ*C_ADDR_WIDTH-1:0] req_araddr;
    logic [C_NUM_REQ*8-1:0]            req_arlen;
    logic [C_NUM_REQ-1:0]              req_rvalid;
    logic [C_NUM_REQ-1:0]              req_rready;
    logic [C_DATA_WIDTH-1:0]           req_rdata;
    logic                              req_rlast;

    logic                              m_axi_arvalid;
    logic                              m_axi_arready;
    logic [C_ADDR_WIDTH-1:0]           m_axi_araddr;
    axi_len_t                          m_axi_arlen;
    logic                              m_axi_rvalid;
    logic                              m_axi_rready;
    logic [C_DATA_WIDTH-1:0]           m_axi_rdata;
    logic                              m_axi_rlast;

    logic [$clog2(C_MAX_OUTSTANDING):0] outstanding;
    logic                               err_unexpected_r;

    // Arbiter side.
    modport master (
        input  req_arvalid, req_araddr, req_arlen, req_rready,
        input  m_axi_arready, m_axi_rvalid, m_axi_rdata, m_axi_rlast,
        output req_arready, req_rvalid, req_rdata, req_rlast,
        output m_axi_arvalid, m_axi_araddr, m_axi_arlen, m_axi_rready,
        output outstanding, err_unexpected_r
    );

    // Read engines plus memory side.
    modport slave (
        output req_arvalid, req_araddr, req_arlen, req_rready,
        output m_axi_arready, m_axi_rvalid, m_axi_rdata, m_axi_rlast,
        input  req_arready, req_rvalid, req_rdata, req_rlast,
        input  m_axi_arvalid, m_axi_araddr, m_axi_arlen, m_axi_rready,
        input  outstanding, err_unexpected_r
    );

endinterface

// File: rtl/krnl_vadd_order_fifo.sv
// Order FIFO of granted requester indices; fall-through head, push+pop legal when full.
module krnl_vadd_order_fifo
    import krnl_vadd_pkg::*;
#(
    parameter int unsigned DEPTH = C_MAX_OUTSTANDING_DFLT,
    parameter int unsigned WIDTH = 2
) (
    input  logic                     ap_clk,
    input  logic                     areset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CNT_W'(DEPTH));
    assign head    = mem[rd_ptr];
    assign do_pop  = pop & ~empty;
    // A pop in the same cycle makes room even when full.
    assign do_push = push & (~full | do_pop);

    always_ff @(posedge ap_clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge ap_clk) begin
        if (areset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/krnl_vadd_rd_arbiter.sv
// Round-robin sharing of one m_axi AR/R pair; R bursts are steered back in issue order.
module krnl_vadd_rd_arbiter
    import krnl_vadd_pkg::*;
#(
    parameter int unsigned C_NUM_REQ         = C_NUM_REQ_DFLT,
    parameter int unsigned C_ADDR_WIDTH      = 64,
    parameter int unsigned C_DATA_WIDTH      = 128,
    parameter int unsigned C_MAX_OUTSTANDING = C_MAX_OUTSTANDING_DFLT
) (
    input  logic                    ap_clk,
    input  logic                    areset,
    krnl_vadd_rd_arbiter_if.master  bus
);

    localparam int unsigned IDX_W = $clog2(C_NUM_REQ);
    localparam int unsigned CNT_W = $clog2(C_MAX_OUTSTANDING) + 1;

    logic [IDX_W-1:0]        rr_ptr_q;
    logic [IDX_W-1:0]        gnt_idx;
    logic [IDX_W-1:0]        head;
    logic                    gnt_found;
    logic                    grant;
    logic                    slot_free;
    logic                    pop;
    logic                    fifo_empty;
    logic                    fifo_full;
    logic [CNT_W-1:0]        count;
    logic [C_DATA_WIDTH-1:0] rdata;
    int unsigned             cand;

    assign pop       = bus.m_axi_rvalid & bus.m_axi_rready & bus.m_axi_rlast;
    assign slot_free = ~bus.m_axi_arvalid | bus.m_axi_arready;
    assign grant     = ~areset & slot_free & (~fifo_full | pop) & gnt_found;

    // First asserted requester at or after the RR pointer, wrapping.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        cand      = 0;
        for (int unsigned k = 0; k < C_NUM_REQ; k++) begin
            cand = (32'(rr_ptr_q) + k) % C_NUM_REQ;
            if (!gnt_found && bus.req_arvalid[cand]) begin
                gnt_found = 1'b1;
                gnt_idx   = IDX_W'(cand);
            end
        end
    end

    assign bus.req_arready = grant ? (C_NUM_REQ'(1) << gnt_idx) : '0;

    always_ff @(posedge ap_clk) begin
        if (areset) begin
            bus.m_axi_arvalid    <= 1'b0;
            bus.m_axi_araddr     <= '0;
            bus.m_axi_arlen      <= '0;
            rr_ptr_q             <= '0;
            bus.err_unexpected_r <= 1'b0;
        end else begin
            if (grant) begin
                bus.m_axi_arvalid <= 1'b1;
                bus.m_axi_araddr  <= bus.req_araddr[32'(gnt_idx)*C_ADDR_WIDTH +: C_ADDR_WIDTH];
                bus.m_axi_arlen   <= bus.req_arlen[32'(gnt_idx)*8 +: 8];
                rr_ptr_q          <= (32'(gnt_idx) == C_NUM_REQ - 1) ? '0
                                                                     : gnt_idx + IDX_W'(1);
            end else if (bus.m_axi_arready) begin
                bus.m_axi_arvalid <= 1'b0;
            end
            if (bus.m_axi_rvalid && fifo_empty) begin
                bus.err_unexpected_r <= 1'b1;
            end
        end
    end

    krnl_vadd_order_fifo #(
        .DEPTH (C_MAX_OUTSTANDING),
        .WIDTH (IDX_W)
    ) u_order_fifo (
        .ap_clk    (ap_clk),
        .areset    (areset),
        .push      (grant),
        .push_data (gnt_idx),
        .pop       (pop),
        .head      (head),
        .empty     (fifo_empty),
        .full      (fifo_full),
        .count     (count)
    );

    // R is routed purely combinationally to the requester at the FIFO head.
    assign rdata            = bus.m_axi_rdata;
    assign bus.req_rdata    = rdata;
    assign bus.req_rlast    = bus.m_axi_rlast;
    assign bus.req_rvalid   = (bus.m_axi_rvalid & ~fifo_empty) ? (C_NUM_REQ'(1) << head) : '0;
    assign bus.m_axi_rready = ~fifo_empty & bus.req_rready[head];
    assign bus.outstanding  = count;

endmodule
